// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe - run-time loadable LUT neuron with a 2-stage lookup pipeline.
//
// The neuron's truth table sits in a distributed RAM. It is (re)loaded through
// a streaming config port, one OUT_BITS entry per cfg_valid beat, in address
// order. Lookups run in a 2-stage pipeline (S1: address register,
// S2: table read into out_data) with valid/ready handshakes on both sides.
//
// Optional macro: LUT_NEURON_PARITY_EN
//   Each table entry also stores an even-parity bit. S2 checks it on read.
//   A sticky out_err port flags any bad result that was delivered.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_start              request a table reload (drains the pipeline first)
//   cfg_valid, cfg_data    table entry beat, address order 0..2^ADDR_W-1
//   cfg_busy               high while draining or loading
//   cfg_done               one-cycle pulse after the last entry is written
//   in_valid/in_ready      input handshake; in_data is the table address
//   in_data                concatenated inputs, input 0 in the LSBs
//   out_valid/out_ready    output handshake
//   out_data               table[in_data]
//   out_err                (parity build only) sticky parity error
module lut_neuron_pipe #(
    parameter int FAN_IN   = 4,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic                        cfg_valid,
    input  logic [OUT_BITS-1:0]         cfg_data,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FAN_IN*IN_BITS-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef LUT_NEURON_PARITY_EN
    output logic [OUT_BITS-1:0]         out_data,
    output logic                        out_err
`else
    output logic [OUT_BITS-1:0]         out_data
`endif
);

    localparam int ADDR_W = FAN_IN * IN_BITS;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int STAGES = 2;
`ifdef LUT_NEURON_PARITY_EN
    localparam int TBL_W  = OUT_BITS + 1;
`else
    localparam int TBL_W  = OUT_BITS;
`endif
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   s1_addr;
    logic [STAGES:1]     vld_pipe;   // [1] = S1 valid, [STAGES] = out_valid
    logic                adv;
    logic                acc;
    logic                last_beat;
    logic [TBL_W-1:0]    mem [DEPTH];
    logic [TBL_W-1:0]    wr_word;
    logic [TBL_W-1:0]    rd_word;

    // The pipeline only stalls when a result is sitting at the output unclaimed.
    assign adv       = !(vld_pipe[STAGES] && !out_ready);
    // cfg_start takes priority over a same-cycle input handshake.
    assign in_ready  = (state == RUN) && adv && !cfg_start;
    assign acc       = in_valid && in_ready;
    assign last_beat = (state == LOAD) && cfg_valid && (cnt == LAST);
    assign cfg_busy  = (state == LOAD) || (state == DRAIN);
    assign out_valid = vld_pipe[STAGES];

    // ---------------- control FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (cfg_start) state_nxt = LOAD;
            LOAD:  if (last_beat) state_nxt = RUN;
            RUN:   if (cfg_start) state_nxt = (vld_pipe == '0) ? LOAD : DRAIN;
            DRAIN: if (vld_pipe == '0) state_nxt = LOAD;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            cnt      <= '0;
            cfg_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cfg_done <= last_beat;
            if (state == LOAD && cfg_valid)
                cnt <= (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
        end
    end

    // ---------------- table RAM (contents not reset) ----------------
`ifdef LUT_NEURON_PARITY_EN
    assign wr_word = {^cfg_data, cfg_data};   // even parity over the stored word
`else
    assign wr_word = cfg_data;
`endif

    always_ff @(posedge clk) begin
        if (state == LOAD && cfg_valid)
            mem[cnt] <= wr_word;
    end

    assign rd_word = mem[s1_addr];

    // ---------------- lookup pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_addr  <= '0;
            out_data <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], acc};
            s1_addr  <= in_data;
            out_data <= rd_word[OUT_BITS-1:0];
        end
    end

`ifdef LUT_NEURON_PARITY_EN
    logic out_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_bad <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (adv)
                out_bad <= ^rd_word;
            // Only results actually handed downstream raise the flag.
            if (cfg_done)
                out_err <= 1'b0;
            else if (out_valid && out_ready && out_bad)
                out_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Scoreboard bench for lut_neuron_pipe: expected table values are pushed at
// input accept and compared at output delivery.
module tb_lut_neuron_pipe;
    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst, cfg_start, cfg_valid, cfg_busy, cfg_done;
    logic [1:0] cfg_data;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data;
    logic [1:0] out_data;
`ifdef LUT_NEURON_PARITY_EN
    logic       out_err;
`endif

    lut_neuron_pipe dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef LUT_NEURON_PARITY_EN
        .out_data(out_data), .out_err(out_err)
`else
        .out_data(out_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] d; int cyc; } exp_t;

    logic [1:0] model [DEPTH];
    exp_t       sb [$];
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0, n_out = 0, n_done = 0, last_out_cyc = 0;
    bit         last_acc, stalled, lat_chk;
    logic [1:0] held;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] tf(int mode, int i);
        logic [7:0] a;
        a = 8'(i);
        case (mode)
            0:       return a[1:0] ^ a[7:6];
            1:       return a[3:2] + a[5:4];
            default: return ~a[1:0] ^ a[5:4];
        endcase
    endfunction

    // Called at a negedge with inputs already driven; observes the handshakes
    // the coming posedge will act on, then advances to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (stalled) chk("stall_hold", out_data, held);
        stalled  = out_valid && !out_ready;
        held     = out_data;
        if (cfg_done) n_done++;
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back('{model[in_data], cyc});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                if (lat_chk) chk("latency", cyc - e.cyc, 2);
            end
            n_out++;
            last_out_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_cfg();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("busy_on_start", cfg_busy, 1);
    endtask

    task automatic load_beats(int n, bit gaps, int mode);
        int i = 0, budget = 0, d0 = n_done;
        while (i < n && budget < 2000) begin
            cfg_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            cfg_data  = tf(mode, i);
            if (cfg_valid) model[i] = cfg_data;
            tick();
            if (cfg_valid) i++;
            budget++;
        end
        cfg_valid = 1'b0;
        chk("load_beats", i, n);
        if (n == DEPTH) begin
            chk("cfg_done", cfg_done, 1);
            chk("busy_after_load", cfg_busy, 0);
            tick();
            chk("cfg_done_clear", cfg_done, 0);
            chk("done_once", n_done - d0, 1);
        end else begin
            chk("busy_mid_load", cfg_busy, 1);
        end
    endtask

    task automatic stream(int n, bit rnd_rdy, int stall_at, bit noise);
        int a = 0, budget = 0, stall_left = 0, got0 = n_out, c0 = cyc;
        bit stall_done = 0;
        lat_chk = !rnd_rdy;
        while (a < n && budget < 5000) begin
            in_valid = 1'b1;
            in_data  = 8'(a);
            if (rnd_rdy) begin
                if (!stall_done && n_out - got0 == stall_at) begin
                    stall_left = 5;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else out_ready = ($urandom_range(2) != 0);
            end else out_ready = 1'b1;
            if (noise) begin
                cfg_valid = 1'($urandom_range(1));
                cfg_data  = 2'($urandom_range(3));
            end
            tick();
            if (last_acc) a++;
            budget++;
        end
        in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            tick();
            budget++;
        end
        chk("drain_empty", sb.size(), 0);
        chk("result_count", n_out - got0, n);
        if (!rnd_rdy) chk("stream_cycles", last_out_cyc - c0 + 1, n + 2);
        lat_chk = 0;
    endtask

    initial begin
        int budget, got0;
        rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = 0;
        in_valid = 0; in_data = 0; out_ready = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        stalled = 0;
        chk("rst_busy", cfg_busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);

        // EMPTY: inputs and stray cfg beats do nothing
        in_valid = 1'b1; cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom_range(255));
            tick();
            chk("empty_out_valid", out_valid, 0);
            chk("empty_in_ready", in_ready, 0);
            chk("empty_busy", cfg_busy, 0);
        end
        in_valid = 1'b0; cfg_valid = 1'b0;

        // first load and full-rate stream, cfg beats in RUN ignored
        start_cfg();
        load_beats(DEPTH, 1, 0);
        stream(DEPTH, 0, 0, 1);

        // random backpressure with a 5-cycle stall at result 17
        stream(DEPTH, 1, 17, 0);

        // cfg_start with 2 results in flight
        budget = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (budget < 10) begin
            in_data = 8'(8'h40 + budget);
            tick();
            budget++;
        end
        chk("inflight", sb.size(), 2);
        cfg_start = 1'b1; in_data = 8'hAA;
        #1;
        chk("cfg_start_wins", in_ready, 0);
        tick();
        cfg_start = 1'b0; in_valid = 1'b0;
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            chk("drain_busy", cfg_busy, 1);
            tick();
            budget++;
        end
        chk("drain_delivered", sb.size(), 0);
        tick();     // DRAIN sees empty stages, moves to LOAD
        load_beats(DEPTH, 0, 1);
        stream(DEPTH, 0, 0, 0);

        // reset in the middle of a load
        start_cfg();
        load_beats(100, 1, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", cfg_busy, 0);
        got0 = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(i);
            tick();
            chk("rst_mid_in_ready", in_ready, 0);
            chk("rst_mid_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        chk("rst_mid_no_out", n_out - got0, 0);
        start_cfg();
        load_beats(DEPTH, 1, 2);
        stream(DEPTH, 1, 3, 0);

`ifdef LUT_NEURON_PARITY_EN
        chk("err_clean", out_err, 0);
        dut.mem[8'hF4] = dut.mem[8'hF4] ^ 3'b001;
        model[8'hF4] = model[8'hF4] ^ 2'b01;
        in_valid = 1'b1; in_data = 8'hF4;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("err_set", out_err, 1);
        repeat (5) tick();
        chk("err_sticky", out_err, 1);
        start_cfg();
        load_beats(DEPTH, 0, 0);
        chk("err_cleared", out_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
